// File: rtl/duck_round_scheduler.sv
// ============================================================================
// duck_round_scheduler : hunt round/duck sequencer with hit-quota grading
// Rev 1.0
// ============================================================================
`default_nettype none

module duck_round_scheduler #(
  parameter int CLK_PER_MS      = 65_000,
  parameter int INTRO_MS        = 3000,
  parameter int FLIGHT_MS       = 5000,
  parameter int RESOLVE_MS      = 2000,
  parameter int DUCKS_PER_ROUND = 10,
  parameter int REQ_HITS        = 6,
  parameter int MAX_ROUND       = 99
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_enable,
  input  logic        hunt_start,
  input  logic        duck_killed,
  input  logic        ammo_empty,
  output logic        duck_spawn,
  output logic        duck_escape,
  output logic        duck_active,
  output logic        round_clear,
  output logic        game_over,
  output logic [6:0]  round_num,
  output logic [3:0]  duck_idx,
  output logic [4:0]  hits,
  output logic [15:0] hit_mask,
  output logic [2:0]  speed_level
);

  localparam logic [31:0] C_INTRO_LOAD   = 32'(INTRO_MS * CLK_PER_MS - 1);
  localparam logic [31:0] C_FLIGHT_LOAD  = 32'(FLIGHT_MS * CLK_PER_MS - 1);
  localparam logic [31:0] C_RESOLVE_LOAD = 32'(RESOLVE_MS * CLK_PER_MS - 1);
  localparam logic [3:0]  C_LAST_DUCK    = 4'(DUCKS_PER_ROUND - 1);
  localparam logic [4:0]  C_HITS_MAX     = 5'(DUCKS_PER_ROUND);
  localparam logic [4:0]  C_REQ_HITS     = 5'(REQ_HITS);
  localparam logic [6:0]  C_MAX_ROUND    = 7'(MAX_ROUND);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ROUND_INTRO = 3'd1,
    S_SPAWN       = 3'd2,
    S_FLYING      = 3'd3,
    S_RESOLVE     = 3'd4,
    S_ROUND_END   = 3'd5,
    S_GAME_OVER   = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic        killed_prev_q;
  logic        spawn_q, spawn_d;
  logic        escape_q, escape_d;
  logic        active_q, active_d;
  logic        clear_q, clear_d;
  logic        over_q, over_d;
  logic [6:0]  round_q, round_d;
  logic [3:0]  idx_q, idx_d;
  logic [4:0]  hits_q, hits_d;
  logic [15:0] mask_q, mask_d;
  logic [2:0]  speed_q, speed_d;
  logic [6:0]  round_m1;
  logic        kill_edge;

  assign kill_edge = duck_killed & ~killed_prev_q;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    spawn_d  = 1'b0;
    escape_d = 1'b0;
    clear_d  = 1'b0;
    active_d = active_q;
    over_d   = over_q;
    round_d  = round_q;
    idx_d    = idx_q;
    hits_d   = hits_q;
    mask_d   = mask_q;
    // Dropping the enable wins over every other transition, from any state.
    if (!game_enable) begin
      state_d  = S_IDLE;
      timer_d  = '0;
      active_d = 1'b0;
      over_d   = 1'b0;
      round_d  = '0;
      idx_d    = '0;
      hits_d   = '0;
      mask_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_ROUND_INTRO;
          timer_d = C_INTRO_LOAD;
          round_d = 7'd1;
          idx_d   = '0;
          hits_d  = '0;
          mask_d  = '0;
        end
        S_ROUND_INTRO: begin
          if (timer_q != 32'd0) timer_d = timer_q - 32'd1;
          else if (hunt_start)  state_d = S_SPAWN;
        end
        S_SPAWN: begin
          spawn_d  = 1'b1;
          active_d = 1'b1;
          timer_d  = C_FLIGHT_LOAD;
          state_d  = S_FLYING;
        end
        S_FLYING: begin
          // A hit in the same cycle as the timeout still counts as a hit.
          if (kill_edge) begin
            mask_d[idx_q] = 1'b1;
            hits_d   = (hits_q == C_HITS_MAX) ? hits_q : hits_q + 5'd1;
            active_d = 1'b0;
            timer_d  = C_RESOLVE_LOAD;
            state_d  = S_RESOLVE;
          end else if (timer_q == 32'd0 || ammo_empty) begin
            escape_d = 1'b1;
            active_d = 1'b0;
            timer_d  = C_RESOLVE_LOAD;
            state_d  = S_RESOLVE;
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
        S_RESOLVE: begin
          if (timer_q != 32'd0) begin
            timer_d = timer_q - 32'd1;
          end else if (idx_q == C_LAST_DUCK) begin
            state_d = S_ROUND_END;
          end else if (hunt_start) begin
            idx_d   = idx_q + 4'd1;
            state_d = S_SPAWN;
          end
        end
        S_ROUND_END: begin
          if (hits_q >= C_REQ_HITS) begin
            clear_d = 1'b1;
            round_d = (round_q >= C_MAX_ROUND) ? C_MAX_ROUND : round_q + 7'd1;
            idx_d   = '0;
            hits_d  = '0;
            mask_d  = '0;
            timer_d = C_INTRO_LOAD;
            state_d = S_ROUND_INTRO;
          end else begin
            over_d  = 1'b1;
            state_d = S_GAME_OVER;
          end
        end
        S_GAME_OVER: state_d = S_GAME_OVER;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // Speed tracks the round being entered so it never lags round_num.
  assign round_m1 = round_d - 7'd1;
  always_comb begin
    speed_d = 3'd0;
    if (round_d != 7'd0) speed_d = (round_m1 > 7'd7) ? 3'd7 : round_m1[2:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      killed_prev_q <= 1'b0;
      spawn_q       <= 1'b0;
      escape_q      <= 1'b0;
      active_q      <= 1'b0;
      clear_q       <= 1'b0;
      over_q        <= 1'b0;
      round_q       <= '0;
      idx_q         <= '0;
      hits_q        <= '0;
      mask_q        <= '0;
      speed_q       <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      killed_prev_q <= duck_killed;
      spawn_q       <= spawn_d;
      escape_q      <= escape_d;
      active_q      <= active_d;
      clear_q       <= clear_d;
      over_q        <= over_d;
      round_q       <= round_d;
      idx_q         <= idx_d;
      hits_q        <= hits_d;
      mask_q        <= mask_d;
      speed_q       <= speed_d;
    end
  end

  assign duck_spawn  = spawn_q;
  assign duck_escape = escape_q;
  assign duck_active = active_q;
  assign round_clear = clear_q;
  assign game_over   = over_q;
  assign round_num   = round_q;
  assign duck_idx    = idx_q;
  assign hits        = hits_q;
  assign hit_mask    = mask_q;
  assign speed_level = speed_q;

endmodule

`default_nettype wire

// File: doc/duck_round_scheduler.md
Name: duck_round_scheduler

Overview:
- Sequences the hunt into rounds of DUCKS_PER_ROUND ducks. Per duck: spawn pulse, flight window, hit/escape resolution.
- Grades each round against a hit quota and then either advances the round or declares game over.
- Sits between the top-level game enable, the shooting/score logic (hunt_start, duck_killed, ammo status) and the duck motion/draw blocks (spawn, active, speed).

Parameters:
- CLK_PER_MS, 65_000, clock cycles per millisecond.
- INTRO_MS, 3000, pause before the first duck of each round.
- FLIGHT_MS, 5000, max flight time before the duck escapes.
- RESOLVE_MS, 2000, pause after a hit/escape before the next duck.
- DUCKS_PER_ROUND, 10, ducks per round (1..16).
- REQ_HITS, 6, hits required to clear a round (1..DUCKS_PER_ROUND).
- MAX_ROUND, 99, round counter saturation value.

Ports:
- clk  in  1  posedge clock
- rst_n  in  1  synchronous reset, active-low
- game_enable  in  1  level; 0 aborts to IDLE from any state
- hunt_start  in  1  level; shooting logic is in its hunting phase
- duck_killed  in  1  level from shooting logic; its rising edge = hit
- ammo_empty  in  1  level; magazine and reserve both zero
- duck_spawn  out  1  one-cycle pulse; motion block starts a new duck
- duck_escape  out  1  one-cycle pulse; current duck flies away
- duck_active  out  1  duck in flight
- round_clear  out  1  one-cycle pulse; round passed
- game_over  out  1  level; quota missed
- round_num  out  7  current round, 1-based
- duck_idx  out  4  index of current duck in round
- hits  out  5  hits in current round
- hit_mask  out  16  bit i = duck i was hit
- speed_level  out  3  min(round_num-1, 7), for duck motion

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, every output 0, round_num 0, timer 0, killed_prev 0.
- Registered outputs. Single down-counter timer (32 bit) loaded with MS*CLK_PER_MS-1.
- kill_edge = duck_killed & ~killed_prev, where killed_prev is registered every cycle.
- State IDLE: all outputs 0. game_enable=1 -> ROUND_INTRO. On this transition: round_num=1, duck_idx=0, hits=0, hit_mask=0, timer=INTRO.
- State ROUND_INTRO: timer decrements to 0 and holds there. Timer==0 and hunt_start=1 -> SPAWN.
- State SPAWN: lasts one cycle. duck_spawn=1 on that cycle, duck_active<=1, timer=FLIGHT -> FLYING.
- State FLYING, checked in priority order:
  - kill_edge: hit_mask[duck_idx]<=1, hits<=hits+1, duck_active<=0, timer=RESOLVE -> RESOLVE.
  - else timer==0 or ammo_empty: duck_escape pulse, duck_active<=0, timer=RESOLVE -> RESOLVE.
  - else: decrement timer.
  - A kill and a timeout/ammo_empty in the same cycle count as a hit.
- State RESOLVE: timer decrements to 0. At timer==0:
  - duck_idx==DUCKS_PER_ROUND-1 -> ROUND_END.
  - else if hunt_start=1: duck_idx++ -> SPAWN.
  - else wait with timer held at 0.
- State ROUND_END (one cycle):
  - hits>=REQ_HITS: round_clear pulse, round_num<=min(round_num+1, MAX_ROUND), duck_idx/hits/hit_mask cleared, timer=INTRO -> ROUND_INTRO.
  - else: game_over<=1 -> GAME_OVER.
- State GAME_OVER: all counters frozen for display, game_over held. game_enable=0 -> IDLE.
- Abort: game_enable=0 in any non-IDLE state -> IDLE next cycle. All outputs cleared and pulses suppressed; this takes priority over every other transition.
- Clamps: hits saturates at DUCKS_PER_ROUND. speed_level = round_num-1 clamped to 7, computed 0 when round_num=0.
- kill_edge outside FLYING is ignored. No double counting of a long duck_killed level.
- Pulses are exactly one cycle and never overlap, except that round_clear may follow the last duck's escape by RESOLVE time.

Test Plan:
Bench overrides: CLK_PER_MS=1, INTRO_MS=4, FLIGHT_MS=10, RESOLVE_MS=3, DUCKS_PER_ROUND=3, REQ_HITS=2.
1. Reset then game_enable=1, hunt_start=1 -> duck_spawn pulses 5 cycles after the enable edge; round_num=1, speed_level=0.
2. No kills -> duck_escape pulses 10 cycles after spawn. After 3 ducks: hits=0, game_over=1, round_num stays 1.
3. kill_edge on ducks 0 and 2 -> hit_mask=0b101, hits=2, round_clear pulse; round_num=2, speed_level=1, then next spawn after intro.
4. duck_killed held high 20 cycles across one flight -> hits increments by exactly 1. Kill coincident with timer==0 -> counted as hit, no duck_escape.
5. ammo_empty=1 mid-flight -> immediate duck_escape. hunt_start=0 in RESOLVE -> no spawn until hunt_start returns.
6. game_enable=0 during FLYING -> IDLE next cycle, all outputs 0. rst_n=0 mid-round -> same, and a fresh enable restarts at round 1.
